cmd_tx_serializer: RTL and testbench

CMD_TX_SERIALIZER -- requirements
Module: cmd_tx_serializer

---
 rtl/cmd_tx_serializer.sv | 174 +++++++++++++++++
 tb/tb_cmd_tx_serializer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_tx_serializer.sv
// cmd_tx_serializer
//   Sends one 48-bit SD command frame per accepted start, MSB first:
//   start bit (0), transmission bit (1), 6-bit index, 32-bit argument,
//   CRC7 (x^7+x^3+1) computed on the fly, end bit (1). A programmable
//   idle gap follows each frame before the next start is accepted.
//
//   state | meaning
//   IDLE  | line released, waiting for start
//   SHIFT | frame bits 47..8 on the line, CRC accumulating
//   CRC   | CRC bits 7..1 on the line
//   END   | end bit on the line, done pulse
//   GAP   | line released, counting down the inter-frame gap
//
// Ports
//   sd_clock   in   clock, all state updates on its rising edge
//   reset      in   asynchronous active-high reset
//   start      in   frame request, honoured only when the block can accept
//   cmd_index  in   6-bit command index, captured with start
//   argument   in   32-bit argument, captured with start
//   cmd_out    out  serial CMD data (idles high)
//   cmd_oe     out  high while a frame is being driven
//   busy       out  high from acceptance until the gap expires
//   done       out  one-cycle pulse concurrent with the end bit
module cmd_tx_serializer #(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CRC   = 3'd2,
    END   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  logic [38:0] shreg_q, shreg_d;    // frame bits 46..8, next bit at [38]
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  function automatic logic [6:0] crc_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cmd_out_d = cmd_out_q;
    cmd_oe_d  = cmd_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: accept = start;

      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd39) begin
          // bit 8 is already on the line, so the CRC is complete here
          cmd_out_d = crc_q[6];
          crc_d     = {crc_q[5:0], 1'b0};
          state_d   = CRC;
        end else begin
          cmd_out_d = shreg_q[38];
          shreg_d   = {shreg_q[37:0], 1'b0};
          crc_d     = crc_step(crc_q, shreg_q[38]);
        end
      end

      CRC: begin
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd46) begin
          cmd_out_d = 1'b1;
          done_d    = 1'b1;
          state_d   = END;
        end else begin
          cmd_out_d = crc_q[6];
          crc_d     = {crc_q[5:0], 1'b0};
        end
      end

      END: begin
        cmd_out_d = 1'b1;
        cmd_oe_d  = 1'b0;
        if (GAP_CYCLES == 0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          accept  = start;
        end else begin
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
        end
      end

      GAP: begin
        // The edge that expires the gap is also the earliest acceptance edge.
        if (gap_cnt_q == 8'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          accept  = start;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = {1'b1, cmd_index, argument};
      crc_d     = 7'd0;
      bit_cnt_d = 6'd0;
      gap_cnt_d = 8'd0;
      cmd_out_d = 1'b0;
      cmd_oe_d  = 1'b1;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      crc_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_out = cmd_out_q;
  assign cmd_oe  = cmd_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cmd_tx_serializer.sv
module tb_cmd_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [5:0]  idx = '0;
  logic [31:0] arg = '0;
  logic        out_a, oe_a, busy_a, done_a;
  logic        out_b, oe_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  logic [47:0] q_a[$];
  logic [47:0] q_b[$];
  logic [47:0] sh_a, sh_b, last_a, last_b;
  int n_a = 0, n_b = 0, frames_a = 0, frames_b = 0;

  always #5 clk = ~clk;

  cmd_tx_serializer #(.GAP_CYCLES(8)) dut_a (
    .sd_clock(clk), .reset(reset), .start(start_a), .cmd_index(idx), .argument(arg),
    .cmd_out(out_a), .cmd_oe(oe_a), .busy(busy_a), .done(done_a)
  );

  cmd_tx_serializer #(.GAP_CYCLES(0)) dut_b (
    .sd_clock(clk), .reset(reset), .start(start_b), .cmd_index(idx), .argument(arg),
    .cmd_out(out_b), .cmd_oe(oe_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [47:0] build_frame(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] hdr;
    logic [6:0]  c;
    logic        fb;
    hdr = {2'b01, i, a};
    c = 7'd0;
    for (int k = 39; k >= 0; k--) begin
      fb = hdr[k] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {hdr, c, 1'b1};
  endfunction

  // Scoreboard monitors: assemble driven bits, pop expected frame on the 48th bit.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      n_a = 0;
      q_a.delete();
    end else if (oe_a) begin
      sh_a = {sh_a[46:0], out_a};
      n_a++;
      if (n_a == 48) begin
        checks++;
        if (done_a !== 1'b1) begin
          errors++;
          $display("FAIL a_done_on_end_bit: got %b want 1", done_a);
        end
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_frame_unexpected: got %h want none", sh_a);
        end else begin
          logic [47:0] e;
          e = q_a.pop_front();
          if (sh_a !== e) begin
            errors++;
            $display("FAIL a_frame: got %h want %h", sh_a, e);
          end
        end
        last_a = sh_a;
        frames_a++;
        n_a = 0;
      end else if (done_a) begin
        checks++;
        errors++;
        $display("FAIL a_done_early: done at bit count %0d want 48", n_a);
      end
    end else if (n_a != 0) begin
      checks++;
      errors++;
      $display("FAIL a_partial_frame: got %0d bits want 48", n_a);
      n_a = 0;
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      n_b = 0;
      q_b.delete();
    end else if (oe_b) begin
      sh_b = {sh_b[46:0], out_b};
      n_b++;
      if (n_b == 48) begin
        checks++;
        if (done_b !== 1'b1) begin
          errors++;
          $display("FAIL b_done_on_end_bit: got %b want 1", done_b);
        end
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_frame_unexpected: got %h want none", sh_b);
        end else begin
          logic [47:0] e;
          e = q_b.pop_front();
          if (sh_b !== e) begin
            errors++;
            $display("FAIL b_frame: got %h want %h", sh_b, e);
          end
        end
        last_b = sh_b;
        frames_b++;
        n_b = 0;
      end else if (done_b) begin
        checks++;
        errors++;
        $display("FAIL b_done_early: done at bit count %0d want 48", n_b);
      end
    end else if (n_b != 0) begin
      checks++;
      errors++;
      $display("FAIL b_partial_frame: got %0d bits want 48", n_b);
      n_b = 0;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if ({out_a, oe_a, busy_a, done_a} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_a out/oe/busy/done: got %b%b%b%b want 1000", out_a, oe_a, busy_a, done_a);
    end
    if ({out_b, oe_b, busy_b, done_b} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_b out/oe/busy/done: got %b%b%b%b want 1000", out_b, oe_b, busy_b, done_b);
    end
    checks -= 6;
  endtask

  // CMD0 started on the very first edge after reset release.
  task automatic test_cmd0();
    int oe_cnt = 0, busy_cnt = 0, done_at = -1, done_cnt = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    idx = 6'd0; arg = 32'h0; start_a = 1'b1;
    q_a.push_back(build_frame(6'd0, 32'h0));
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (oe_a) oe_cnt++;
      if (busy_a) busy_cnt++;
      if (done_a) begin done_at = k; done_cnt++; end
      if (k == 48) begin
        checks++;
        if ({out_a, oe_a} !== 2'b10) begin
          errors++;
          $display("FAIL cmd0_post_frame out/oe: got %b%b want 10", out_a, oe_a);
        end
      end
    end
    checks++;
    if (last_a !== 48'h400000000095) begin
      errors++;
      $display("FAIL cmd0_stream: got %h want 400000000095", last_a);
    end
    checks++;
    if (oe_cnt != 48) begin
      errors++;
      $display("FAIL cmd0_oe_cycles: got %0d want 48", oe_cnt);
    end
    checks++;
    if (busy_cnt != 56) begin
      errors++;
      $display("FAIL cmd0_busy_cycles: got %0d want 56", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 47) begin
      errors++;
      $display("FAIL cmd0_done: got %0d pulses last at %0d want 1 at 47", done_cnt, done_at);
    end
  endtask

  task automatic test_cmd8();
    int f0 = frames_a;
    @(posedge clk);
    #1 idx = 6'd8; arg = 32'h000001AA; start_a = 1'b1;
    q_a.push_back(build_frame(6'd8, 32'h000001AA));
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (last_a !== 48'h48000001AA87 || frames_a != f0 + 1) begin
      errors++;
      $display("FAIL cmd8_stream: got %h (frames %0d) want 48000001aa87 (frames %0d)", last_a, frames_a, f0 + 1);
    end
  endtask

  // CMD17 with start held: second frame must start on edge E0+56.
  task automatic test_gap8();
    int rise_at = -1, oe_cnt = 0, f0 = frames_a;
    logic prev = 1'b1;
    @(posedge clk);
    #1 idx = 6'd17; arg = 32'h0; start_a = 1'b1;
    q_a.push_back(build_frame(6'd17, 32'h0));
    q_a.push_back(build_frame(6'd17, 32'h0));
    @(posedge clk);
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (oe_a) oe_cnt++;
      if (oe_a && !prev && rise_at < 0) rise_at = k;
      prev = oe_a;
      if (k == 56) start_a = 1'b0;
    end
    checks++;
    if (rise_at != 56) begin
      errors++;
      $display("FAIL gap8_second_start: got cycle %0d want 56", rise_at);
    end
    checks++;
    if (oe_cnt != 96 || frames_a != f0 + 2) begin
      errors++;
      $display("FAIL gap8_frames: got oe %0d frames %0d want oe 96 frames %0d", oe_cnt, frames_a - f0, 2);
    end
    checks++;
    if (last_a !== 48'h510000000055) begin
      errors++;
      $display("FAIL gap8_stream: got %h want 510000000055", last_a);
    end
  endtask

  // GAP_CYCLES=0: CMD0 then CMD8 with no idle cycle between them.
  task automatic test_back_to_back();
    int oe_cnt = 0, done_cnt = 0, done_bad = 0, f0 = frames_b;
    @(posedge clk);
    #1 idx = 6'd0; arg = 32'h0; start_b = 1'b1;
    q_b.push_back(build_frame(6'd0, 32'h0));
    @(posedge clk);
    #1 idx = 6'd8; arg = 32'h000001AA;
    q_b.push_back(build_frame(6'd8, 32'h000001AA));
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (oe_b) oe_cnt++;
      if (done_b) begin
        done_cnt++;
        if (k != 47 && k != 95) done_bad++;
      end
      if (k == 48) start_b = 1'b0;
      if (k == 95) begin
        checks++;
        if (oe_cnt != 96) begin
          errors++;
          $display("FAIL b2b_contiguous_oe: got %0d want 96", oe_cnt);
        end
      end
    end
    checks++;
    if (done_cnt != 2 || done_bad != 0) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses (%0d misplaced) want 2 at 47,95", done_cnt, done_bad);
    end
    checks++;
    if (oe_cnt != 96 || frames_b != f0 + 2 || last_b !== 48'h48000001AA87) begin
      errors++;
      $display("FAIL b2b_frames: got oe %0d frames %0d last %h want 96 2 48000001aa87",
               oe_cnt, frames_b - f0, last_b);
    end
  endtask

  // start pulses in SHIFT, CRC, END and GAP plus mid-frame argument changes.
  task automatic test_ignore();
    int oe_cnt = 0, busy_cnt = 0, f0 = frames_a;
    logic [31:0] a;
    a = $urandom;
    @(posedge clk);
    #1 idx = 6'd55; arg = a; start_a = 1'b1;
    q_a.push_back(build_frame(6'd55, a));
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (oe_a) oe_cnt++;
      if (busy_a) busy_cnt++;
      if (k == 5) begin idx = 6'd3; arg = ~a; end
      start_a = (k == 10 || k == 42 || k == 47 || k == 50);
    end
    start_a = 1'b0;
    checks++;
    if (oe_cnt != 48 || busy_cnt != 56 || frames_a != f0 + 1) begin
      errors++;
      $display("FAIL ignore_start: got oe %0d busy %0d frames %0d want 48 56 1", oe_cnt, busy_cnt, frames_a - f0);
    end
  endtask

  // Reset during bit 20 of CMD17, then a clean CMD8 frame.
  task automatic test_reset_abort();
    int f0;
    logic [31:0] a;
    @(posedge clk);
    #1 idx = 6'd17; arg = 32'h0; start_a = 1'b1;
    q_a.push_back(build_frame(6'd17, 32'h0));
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (21) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_a, oe_a, busy_a, done_a} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_outputs out/oe/busy/done: got %b%b%b%b want 1000", out_a, oe_a, busy_a, done_a);
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    f0 = frames_a;
    a = $urandom;
    idx = 6'd8; arg = a; start_a = 1'b1;
    q_a.push_back(build_frame(6'd8, a));
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (frames_a != f0 + 1 || last_a !== build_frame(6'd8, a)) begin
      errors++;
      $display("FAIL abort_recovery: got frames %0d last %h want 1 %h", frames_a - f0, last_a, build_frame(6'd8, a));
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_gap8();
    test_back_to_back();
    test_ignore();
    test_reset_abort();
    repeat (5) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
